// File: rtl/spi_dev_shift.sv
// SPI responder character shift engine: synchronises sclk/cs_n/mosi into clk, shifts rx/tx characters.
// Optional sticky status (stat_clr, rx_overrun, tx_underrun) is built when SPI_DEV_STATUS_EN is defined.
module spi_dev_shift #(
    parameter int CHAR_LEN = 8,
    parameter int CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsb,
    input  logic                sclk,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic [CHAR_LEN-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [CHAR_LEN-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
`ifdef SPI_DEV_STATUS_EN
    input  logic                stat_clr,
    output logic                rx_overrun,
    output logic                tx_underrun,
`endif
    output logic                busy
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [CNT_W-1:0]    LAST = CNT_W'(CHAR_LEN - 1);
    localparam logic [CHAR_LEN-1:0] ONE  = {{(CHAR_LEN-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic cs_s1_q, cs_s2_q, cs_h_q;
    logic mosi_s1_q, mosi_s2_q, mosi_h_q;

    logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [CNT_W-1:0]    tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic [CHAR_LEN-1:0] tx_sr_q, tx_sr_d, buf_q, buf_d;
    logic                buf_full_q, buf_full_d, miso_q, miso_d;
    logic [CHAR_LEN-1:0] rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                active_c;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, edge_en;
    logic lead, trail, sample, launch, load, wr, tx_lsb, complete;
    logic [CHAR_LEN-1:0] tx_src, rx_shift;
    logic [CNT_W-1:0]    pos;

    // cs_n synchroniser clears to 0 (not idle-high): if cs_n is already low when
    // reset releases, no cs_fall fires and the in-flight transaction is skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1_q <= 1'b0; sclk_s2_q <= 1'b0; sclk_h_q <= 1'b0;
            cs_s1_q   <= 1'b0; cs_s2_q   <= 1'b0; cs_h_q   <= 1'b0;
            mosi_s1_q <= 1'b0; mosi_s2_q <= 1'b0; mosi_h_q <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;      sclk_s2_q <= sclk_s1_q; sclk_h_q <= sclk_s2_q;
            cs_s1_q   <= cs_n;      cs_s2_q   <= cs_s1_q;   cs_h_q   <= cs_s2_q;
            mosi_s1_q <= mosi;      mosi_s2_q <= mosi_s1_q; mosi_h_q <= mosi_s2_q;
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_h_q;
    assign sclk_fall = ~sclk_s2_q & sclk_h_q;
    assign cs_fall   = cs_h_q & ~cs_s2_q;
    assign cs_rise   = ~cs_h_q & cs_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        active_c = 1'b0;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE: begin
                active_c = 1'b1;
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = active_c;
    assign miso_oe = active_c;

    // Edge classification; sclk edges count only inside an accepted transaction.
    always_comb begin
        edge_en  = (state_q == ACTIVE) && !cs_rise;
        lead     = edge_en && (cpol_q ? sclk_fall : sclk_rise);
        trail    = edge_en && (cpol_q ? sclk_rise : sclk_fall);
        sample   = cpha_q ? trail : lead;
        // The cs_fall launch happens before the mode latch updates, so it reads the pins.
        launch   = ((state_q == IDLE) && cs_fall && !cpha) || (cpha_q ? lead : trail);
        tx_lsb   = (state_q == IDLE) ? lsb : lsb_q;
        load     = launch && (tx_idx_q == '0);
        wr       = tx_valid && !buf_full_q;
        tx_src   = load ? (buf_full_q ? buf_q : '1) : tx_sr_q;
        pos      = tx_lsb ? tx_idx_q : LAST - tx_idx_q;
        rx_shift = lsb_q ? {mosi_h_q, rx_sr_q[CHAR_LEN-1:1]}
                         : {rx_sr_q[CHAR_LEN-2:0], mosi_h_q};
        complete = sample && (rx_idx_q == LAST);
    end

    always_comb begin
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        tx_idx_d   = tx_idx_q;
        tx_sr_d    = tx_sr_q;
        miso_d     = miso_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        rx_idx_d   = rx_idx_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;

        if ((state_q == IDLE) && cs_fall) begin
            cpol_d = cpol;
            cpha_d = cpha;
            lsb_d  = lsb;
        end

        if (launch) begin
            tx_sr_d  = tx_src;
            miso_d   = |(tx_src & (ONE << pos));
            tx_idx_d = (tx_idx_q == LAST) ? '0 : tx_idx_q + 1'b1;
        end

        // A same-cycle write lands after the load has taken the old contents.
        if (load) buf_full_d = 1'b0;
        if (wr) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (sample) begin
            rx_sr_d  = rx_shift;
            rx_idx_d = complete ? '0 : rx_idx_q + 1'b1;
        end
        if (complete) begin
            rx_data_d  = rx_shift;
            rx_valid_d = 1'b1;
        end

        if ((state_q == ACTIVE) && cs_rise) begin
            tx_idx_d = '0;
            rx_idx_d = '0;
            rx_sr_d  = '0;
            miso_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            tx_idx_q   <= '0;
            tx_sr_q    <= '0;
            miso_q     <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            rx_idx_q   <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            tx_idx_q   <= tx_idx_d;
            tx_sr_q    <= tx_sr_d;
            miso_q     <= miso_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            rx_idx_q   <= rx_idx_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign miso     = miso_q;
    assign tx_ready = !buf_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef SPI_DEV_STATUS_EN
    logic ovr_q, ovr_d, und_q, und_d;

    always_comb begin
        ovr_d = ovr_q;
        und_d = und_q;
        if (stat_clr) begin
            ovr_d = 1'b0;
            und_d = 1'b0;
        end
        if (complete && rx_valid_q && !rx_ready) ovr_d = 1'b1;
        if (load && !buf_full_q)                 und_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
            und_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            und_q <= und_d;
        end
    end

    assign rx_overrun  = ovr_q;
    assign tx_underrun = und_q;
`endif

endmodule

// File: doc/spi_dev_shift.md
Name: spi_dev_shift

Overview:
- SPI device-side (responder) character shift engine, sitting opposite the host shift block on the same bus.
- Samples external sclk/cs_n/mosi in the clk domain and drives miso.
- Deserialises host characters into rx_data with a valid/ready handshake.
- Serialises characters taken from a one-entry tx holding buffer loaded via valid/ready.
- Supports all four CPOL/CPHA modes and MSB- or LSB-first ordering.

Parameters:
- CHAR_LEN, 8: bits per character; legal range 2..32.
- CNT_W, 5: bit-index counter width; must satisfy 2^CNT_W >= CHAR_LEN.

Ports:
- clk  in  1  system clock; must run at least 8x sclk.
- rst  in  1  asynchronous active-high reset.
- cpol  in  1  sclk idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- lsb  in  1  1: LSB first on both mosi and miso.
- sclk  in  1  SPI clock, asynchronous.
- cs_n  in  1  chip select, active low, asynchronous.
- mosi  in  1  serial data from host, asynchronous.
- miso  out  1  serial data to host.
- miso_oe  out  1  miso output enable.
- tx_data  in  CHAR_LEN  character for the next transmission.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding buffer empty.
- rx_data  out  CHAR_LEN  last received character.
- rx_valid  out  1  rx_data holds an unconsumed character.
- rx_ready  in  1  consumer accepts rx_data.
- busy  out  1  cs_n active (synchronised).

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All state clears. Output reset values: miso=0, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0.
- Synchronisers:
  - sclk, cs_n and mosi each pass through a 2-flop synchroniser plus one history flop.
  - Edge detect compares synchroniser output with history; events fire 3 clk cycles after the pin change.
- cs_fall and cs_rise are detected on synchronised cs_n.
- Mode latch: cpol, cpha and lsb are captured into internal registers at cs_fall. Changes during a transaction are ignored.
- Edge classification:
  - leading edge = synced sclk rising when cpol=0, falling when cpol=1; trailing edge is the opposite transition.
  - sample event: leading when cpha=0, trailing when cpha=1.
  - launch event: (cs_fall or trailing) when cpha=0; leading when cpha=1.
  - sclk edges are ignored while cs_n is inactive.
- State machine:
  - IDLE -> ACTIVE on cs_fall. While ACTIVE: busy=1, miso_oe=1.
  - ACTIVE -> IDLE on cs_rise. On this transition: miso_oe=0, bit counters clear, any partial rx character is discarded, and the tx holding buffer is kept.
- Transmit path:
  - tx_idx counts 0..CHAR_LEN-1 and wraps.
  - At a launch event with tx_idx=0: load tx_sr from the holding buffer, or all-ones if the buffer is empty (underrun). Then drive miso with the first bit: tx_sr[CHAR_LEN-1] for MSB-first, tx_sr[0] for LSB-first.
  - At a launch event with tx_idx!=0: drive miso with the next bit.
  - miso updates in the clk cycle after the event. tx_idx increments at every launch event.
- Holding buffer:
  - tx_valid && tx_ready writes the buffer and sets tx_ready=0 next cycle.
  - A load into tx_sr empties the buffer (tx_ready=1 next cycle).
  - If a write and a load occur in the same cycle, the load takes the old contents and the new write occupies the buffer.
- Receive path:
  - At each sample event, rx_sr shifts in synced mosi. MSB-first shifts left with insertion at bit 0; LSB-first shifts right with insertion at bit CHAR_LEN-1.
  - rx_idx counts samples. On the CHAR_LEN-th sample, the completed character is written to rx_data, rx_valid=1 next cycle, and rx_idx wraps to 0.
  - rx_valid && rx_ready clears rx_valid.
  - If a completion coincides with a handshake, rx_valid stays 1 with the new data.
  - If a completion occurs while rx_valid=1 with no handshake, rx_data is overwritten (overrun).
- Reset mid-transaction: returns to IDLE. A transaction already in flight is ignored until the next cs_fall.

Optional Feature:
- Macro SPI_DEV_STATUS_EN.
- Defined: adds an input stat_clr (1 bit) and sticky outputs rx_overrun and tx_underrun (reset 0).
  - rx_overrun is set on an overwrite of an unconsumed rx_data.
  - tx_underrun is set on a load with an empty buffer.
  - stat_clr clears both; a set in the same cycle wins over the clear.
- Undefined: these ports and their logic are absent; overrun and underrun occur silently as described above.

Test Plan:
- Mode 0 (cpol=0, cpha=0), MSB-first: buffer 0xA5, host sends 0x3C -> miso sequence 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1; tx_ready returns to 1 after the cs_fall load.
- Mode 3 (cpol=1, cpha=1), lsb=1: buffer 0x81, host sends 0x01 -> miso sequence 1,0,0,0,0,0,0,1; rx_data=0x01.
- Back-to-back: two characters under one cs_n, buffer refilled with 0x11 after the first load -> second miso character is 0x11; rx_valid is held with rx_ready=0 -> rx_data equals the second character (overrun flag set if SPI_DEV_STATUS_EN).
- Empty buffer at cs_fall -> miso all ones for the character (tx_underrun set if SPI_DEV_STATUS_EN).
- cs_n deasserted after 5 of 8 bits, then a new full transaction sending 0x5A -> no rx_valid for the partial character; rx_data=0x5A.
- rst asserted mid-character -> all outputs at reset values in the same cycle; the next full transaction completes correctly.
